// File: rtl/mii_tx_nibble_ser_pkg.sv
// Shared ethernet constants for the MII transmit path.
//   IFG_BYTES_DEF : default minimum inter-frame gap, in byte times
//   MII_W         : MII data nibble width
package mii_tx_nibble_ser_pkg;
  localparam int IFG_BYTES_DEF = 12;
  localparam int MII_W         = 4;
endpackage

// File: rtl/mii_tx_nibble_ser.sv
// AXI-stream byte to 4-bit SDR MII transmit serializer (low nibble first).
// Runs entirely in the PHY TX clock domain. It enforces a minimum IFG,
// carries tuser onto tx_er for both nibbles of a byte, and turns a
// mid-frame stream underflow into an errored frame that is drained
// up to tlast.
//   clk, rst_n          : TX clock, async active-low reset
//   s_axis_t*           : byte stream in (tdata, tvalid, tready, tlast, tuser)
//   mii_txd/tx_en/tx_er : registered pin outputs (IOB-packed)
//   status_underflow    : one-cycle pulse when an underflow is detected
module mii_tx_nibble_ser
  import mii_tx_nibble_ser_pkg::*;
#(
  parameter int IFG_BYTES = IFG_BYTES_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       s_axis_tdata,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  input  logic             s_axis_tlast,
  input  logic             s_axis_tuser,
  output logic [MII_W-1:0] mii_txd,
  output logic             mii_tx_en,
  output logic             mii_tx_er,
  output logic             status_underflow
);

  localparam int CNT_W = $clog2(2*IFG_BYTES);
  // Normal frame end: the counter starts one edge before tx_en falls.
  localparam logic [CNT_W-1:0] IFG_LOAD    = CNT_W'(2*IFG_BYTES-1);
  // Underflow drain: tx_en falls at the same edge the counter starts,
  // so one count fewer keeps the idle gap at 2*IFG_BYTES cycles.
  localparam logic [CNT_W-1:0] IFG_LOAD_UF = CNT_W'(2*IFG_BYTES-2);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND_HI,
    ST_SEND_LO,
    ST_UNDERFLOW,
    ST_IFG
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       hold_q, hold_d;
  logic             err_r_q, err_r_d;
  logic             last_r_q, last_r_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             uf_q, uf_d;

  (* IOB = "TRUE" *) logic [MII_W-1:0] txd_q;
  (* IOB = "TRUE" *) logic             tx_en_q;
  (* IOB = "TRUE" *) logic             tx_er_q;
  logic [MII_W-1:0] txd_d;
  logic             tx_en_d, tx_er_d;

  logic accept;

  always_comb begin
    s_axis_tready = 1'b0;
    case (state_q)
      ST_IDLE:      s_axis_tready = 1'b1;
      ST_SEND_HI:   s_axis_tready = !last_r_q;
      ST_UNDERFLOW: s_axis_tready = 1'b1;
      default:      s_axis_tready = 1'b0;
    endcase
  end

  assign accept = s_axis_tvalid && s_axis_tready;

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    err_r_d  = err_r_q;
    last_r_d = last_r_q;
    cnt_d    = cnt_q;
    uf_d     = 1'b0;
    txd_d    = '0;
    tx_en_d  = 1'b0;
    tx_er_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          txd_d    = s_axis_tdata[3:0];
          tx_en_d  = 1'b1;
          tx_er_d  = s_axis_tuser;
          hold_d   = s_axis_tdata;
          err_r_d  = s_axis_tuser;
          last_r_d = s_axis_tlast;
          state_d  = ST_SEND_HI;
        end
      end
      ST_SEND_HI: begin
        txd_d   = hold_q[7:4];
        tx_en_d = 1'b1;
        tx_er_d = err_r_q;
        if (last_r_q) begin
          cnt_d   = IFG_LOAD;
          state_d = ST_IFG;
        end else if (accept) begin
          hold_d   = s_axis_tdata;
          err_r_d  = s_axis_tuser;
          last_r_d = s_axis_tlast;
          state_d  = ST_SEND_LO;
        end else begin
          uf_d    = 1'b1;
          state_d = ST_UNDERFLOW;
        end
      end
      ST_SEND_LO: begin
        txd_d   = hold_q[3:0];
        tx_en_d = 1'b1;
        tx_er_d = err_r_q;
        state_d = ST_SEND_HI;
      end
      ST_UNDERFLOW: begin
        // Accepted bytes are dropped; the frame stays errored until tlast.
        if (accept && s_axis_tlast) begin
          cnt_d   = IFG_LOAD_UF;
          state_d = ST_IFG;
        end else begin
          tx_en_d = 1'b1;
          tx_er_d = 1'b1;
        end
      end
      ST_IFG: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      hold_q   <= '0;
      err_r_q  <= 1'b0;
      last_r_q <= 1'b0;
      cnt_q    <= '0;
      uf_q     <= 1'b0;
      txd_q    <= '0;
      tx_en_q  <= 1'b0;
      tx_er_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      err_r_q  <= err_r_d;
      last_r_q <= last_r_d;
      cnt_q    <= cnt_d;
      uf_q     <= uf_d;
      txd_q    <= txd_d;
      tx_en_q  <= tx_en_d;
      tx_er_q  <= tx_er_d;
    end
  end

  assign mii_txd          = txd_q;
  assign mii_tx_en        = tx_en_q;
  assign mii_tx_er        = tx_er_q;
  assign status_underflow = uf_q;

endmodule
